// File: rtl/link_arbiter.sv
// link_arbiter: two 4-phase req/ack masters sharing one slave link.
// Grants whole bursts; releases on BURST handshakes or GAP idle cycles.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   m0_req/m0_data     master 0 request and byte (in), m0_ack (out)
//   m1_req/m1_data     master 1 request and byte (in), m1_ack (out)
//   s_req/s_data       forwarded request and byte to the slave (out)
//   s_ack              slave acknowledge (in)
//   grant              registered one-hot owner, 01=m0 10=m1 00=none
//   busy               high whenever a master owns the link
module link_arbiter #(
    parameter int unsigned BURST = 4,
    parameter int unsigned GAP   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m0_req,
    input  logic [7:0] m0_data,
    output logic       m0_ack,
    input  logic       m1_req,
    input  logic [7:0] m1_data,
    output logic       m1_ack,
    output logic       s_req,
    output logic [7:0] s_data,
    input  logic       s_ack,
    output logic [1:0] grant,
    output logic       busy
);

    localparam logic [3:0] BURST_C = 4'(BURST);
    localparam logic [3:0] GAP_C   = 4'(GAP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_ACKED,
        ST_GAP
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [3:0] tmr_q,   tmr_d;
    logic       pri_q,   pri_d;

    logic       own_req;
    logic       pick_m1;
    logic [3:0] cnt_inc;
    logic [3:0] tmr_inc;

    // Only the granted master's request can ever reach the slave.
    assign own_req = (grant_q[0] & m0_req) | (grant_q[1] & m1_req);

    // m1 wins when it asks alone, or on a tie while pri favours it.
    assign pick_m1 = m1_req & (~m0_req | pri_q);

    assign cnt_inc = cnt_q + 4'd1;
    assign tmr_inc = tmr_q + 4'd1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        pri_d   = pri_q;
        unique case (state_q)
            ST_IDLE: begin
                if (m0_req | m1_req) begin
                    state_d = ST_OWN;
                    grant_d = pick_m1 ? 2'b10 : 2'b01;
                    cnt_d   = 4'd0;
                    tmr_d   = 4'd0;
                end
            end
            ST_OWN: begin
                // An owner that drops req early just parks here.
                if (s_ack) begin
                    state_d = ST_ACKED;
                end
            end
            ST_ACKED: begin
                if (!s_ack) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == BURST_C) begin
                        state_d = ST_IDLE;
                        grant_d = 2'b00;
                        // Favour the other master next time.
                        pri_d   = grant_q[0];
                    end else begin
                        state_d = ST_GAP;
                        tmr_d   = 4'd0;
                    end
                end
            end
            ST_GAP: begin
                if (own_req) begin
                    state_d = ST_OWN;
                end else begin
                    tmr_d = tmr_inc;
                    if (tmr_inc == GAP_C) begin
                        state_d = ST_IDLE;
                        grant_d = 2'b00;
                        pri_d   = grant_q[0];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            cnt_q   <= 4'd0;
            tmr_q   <= 4'd0;
            pri_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            pri_q   <= pri_d;
        end
    end

    assign grant  = grant_q;
    assign busy   = |grant_q;
    assign s_req  = own_req;
    assign s_data = ({8{grant_q[0]}} & m0_data)
                  | ({8{grant_q[1]}} & m1_data);
    assign m0_ack = grant_q[0] & s_ack;
    assign m1_ack = grant_q[1] & s_ack;

endmodule

// File: tb/tb_link_arbiter.sv
// tb_link_arbiter: vector table, directed sequences and a randomized
// run against a behavioural model of the link arbiter.
module tb_link_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, m0_req, m1_req, s_ack;
    logic [7:0] m0_data, m1_data;
    logic       m0_ack, m1_ack, s_req, busy;
    logic [7:0] s_data;
    logic [1:0] grant;

    logic       rst_b, m0_req_b, m1_req_b, s_ack_b;
    logic [7:0] m0_data_b, m1_data_b;
    logic       m0_ack_b, m1_ack_b, s_req_b, busy_b;
    logic [7:0] s_data_b;
    logic [1:0] grant_b;

    link_arbiter #(.BURST(4), .GAP(3)) u0 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_data(m0_data), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_data(m1_data), .m1_ack(m1_ack),
        .s_req(s_req), .s_data(s_data), .s_ack(s_ack),
        .grant(grant), .busy(busy)
    );

    link_arbiter #(.BURST(1), .GAP(3)) u1 (
        .clk(clk), .rst(rst_b),
        .m0_req(m0_req_b), .m0_data(m0_data_b), .m0_ack(m0_ack_b),
        .m1_req(m1_req_b), .m1_data(m1_data_b), .m1_ack(m1_ack_b),
        .s_req(s_req_b), .s_data(s_data_b), .s_ack(s_ack_b),
        .grant(grant_b), .busy(busy_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    // Behavioural model of u0 (BURST=4, GAP=3).
    localparam int MB = 4;
    localparam int MG = 3;
    int  own = -1;
    int  done = 0;
    int  idle_n = 0;
    int  fav = 0;
    bit  ackd = 0;
    bit  gapping = 0;
    bit  mon = 0;

    function automatic void release_own();
        fav = 1 - own;
        own = -1;
    endfunction

    function automatic void model_edge();
        bit rq [2];
        rq[0] = m0_req;
        rq[1] = m1_req;
        if (rst) begin
            own = -1; done = 0; idle_n = 0; fav = 0;
            ackd = 0; gapping = 0;
        end else if (own < 0) begin
            if (rq[0] || rq[1]) begin
                own = (rq[0] && rq[1]) ? fav : (rq[0] ? 0 : 1);
                done = 0; ackd = 0; gapping = 0;
            end
        end else if (gapping) begin
            if (rq[own]) gapping = 0;
            else begin
                idle_n++;
                if (idle_n == MG) release_own();
            end
        end else if (!ackd) begin
            if (s_ack) ackd = 1;
        end else if (!s_ack) begin
            done++;
            ackd = 0;
            if (done == MB) release_own();
            else begin
                gapping = 1;
                idle_n = 0;
            end
        end
    endfunction

    task automatic model_chk();
        logic [1:0] eg;
        logic       esr, ea0, ea1;
        logic [7:0] esd;
        eg  = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
        esr = (own == 0) ? m0_req : (own == 1) ? m1_req : 1'b0;
        esd = (own == 0) ? m0_data : (own == 1) ? m1_data : 8'h00;
        ea0 = (own == 0) && s_ack;
        ea1 = (own == 1) && s_ack;
        chk("mdl grant", 8'(grant), 8'(eg));
        chk("mdl busy", 8'(busy), 8'(own >= 0));
        chk("mdl s_req", 8'(s_req), 8'(esr));
        chk("mdl s_data", s_data, esd);
        chk("mdl m0_ack", 8'(m0_ack), 8'(ea0));
        chk("mdl m1_ack", 8'(m1_ack), 8'(ea1));
    endtask

    logic [1:0] o_g, ob_g;
    logic       o_sr, o_a0, o_a1, o_busy;
    logic       ob_sr, ob_a0, ob_a1;
    logic [7:0] o_sd, ob_sd;
    logic [7:0] seen [$];

    task automatic tick();
        @(negedge clk);
        o_g = grant; o_sr = s_req; o_sd = s_data;
        o_a0 = m0_ack; o_a1 = m1_ack; o_busy = busy;
        ob_g = grant_b; ob_sr = s_req_b; ob_sd = s_data_b;
        ob_a0 = m0_ack_b; ob_a1 = m1_ack_b;
        if (mon) model_chk();
        if (s_req && s_ack) seen.push_back(s_data);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step(input logic r, input logic r0, input logic [7:0] d0,
                        input logic r1, input logic [7:0] d1, input logic sa);
        rst = r; m0_req = r0; m0_data = d0;
        m1_req = r1; m1_data = d1; s_ack = sa;
        tick();
    endtask

    task automatic step_b(input logic r0, input logic [7:0] d0,
                          input logic r1, input logic [7:0] d1, input logic sa);
        m0_req_b = r0; m0_data_b = d0;
        m1_req_b = r1; m1_data_b = d1; s_ack_b = sa;
        tick();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    // One full 4-phase handshake by master m on u0, other master static.
    task automatic hs(input bit m, input logic [7:0] b,
                      input logic orq, input logic [7:0] od);
        logic r, sa;
        for (int i = 0; i < 4; i++) begin
            r  = (i < 2);
            sa = (i == 1 || i == 2);
            if (!m) step(1'b0, r, b, orq, od, sa);
            else    step(1'b0, orq, od, r, b, sa);
            chk("hs grant", 8'(o_g), m ? 8'h02 : 8'h01);
            chk("hs data", o_sd, b);
            chk("hs sreq", 8'(o_sr), 8'(r));
            chk("hs ack", 8'(m ? o_a1 : o_a0), 8'(sa));
            chk("hs other ack", 8'(m ? o_a0 : o_a1), 8'h00);
        end
    endtask

    typedef struct packed {
        logic       r0;
        logic [7:0] d0;
        logic       r1;
        logic [7:0] d1;
        logic       sa;
        logic [1:0] g;
        logic       sr;
        logic [7:0] sd;
        logic       a0;
        logic       a1;
    } vec_t;

    function automatic vec_t mkv(
        input logic r0, input logic [7:0] d0,
        input logic r1, input logic [7:0] d1, input logic sa,
        input logic [1:0] g, input logic sr, input logic [7:0] sd,
        input logic a0, input logic a1);
        vec_t v;
        v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1; v.sa = sa;
        v.g = g; v.sr = sr; v.sd = sd; v.a0 = a0; v.a1 = a1;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: no finish after %0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t       tbl [$];
        logic [7:0] b, d0, d1;
        logic       r, r0, r1, sa;
        int         ow;
        logic [7:0] want [$];

        // m0 alone sends A0..A3; m1 data must never leak.
        tbl.push_back(mkv(1, 8'hA0, 0, 8'hB7, 0, 2'b00, 0, 8'h00, 0, 0));
        for (int k = 0; k < 4; k++) begin
            b = 8'(8'hA0 + k);
            tbl.push_back(mkv(1, b, 0, 8'hB7, 0, 2'b01, 1, b, 0, 0));
            tbl.push_back(mkv(1, b, 0, 8'hB7, 1, 2'b01, 1, b, 1, 0));
            tbl.push_back(mkv(0, b, 0, 8'hB7, 1, 2'b01, 0, b, 1, 0));
            tbl.push_back(mkv(0, b, 0, 8'hB7, 0, 2'b01, 0, b, 0, 0));
        end
        tbl.push_back(mkv(0, 8'hA3, 0, 8'hB7, 0, 2'b00, 0, 8'h00, 0, 0));
        // m1 one byte, then m0 asks during m1's gap and waits it out.
        tbl.push_back(mkv(0, 8'h11, 1, 8'hB1, 0, 2'b00, 0, 8'h00, 0, 0));
        tbl.push_back(mkv(0, 8'h11, 1, 8'hB1, 0, 2'b10, 1, 8'hB1, 0, 0));
        tbl.push_back(mkv(0, 8'h11, 1, 8'hB1, 1, 2'b10, 1, 8'hB1, 0, 1));
        tbl.push_back(mkv(0, 8'h11, 0, 8'hB1, 1, 2'b10, 0, 8'hB1, 0, 1));
        tbl.push_back(mkv(0, 8'h11, 0, 8'hB1, 0, 2'b10, 0, 8'hB1, 0, 0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mkv(1, 8'hA5, 0, 8'hB1, 0, 2'b10, 0, 8'hB1, 0, 0));
        tbl.push_back(mkv(1, 8'hA5, 0, 8'hB1, 0, 2'b00, 0, 8'h00, 0, 0));
        tbl.push_back(mkv(1, 8'hA5, 0, 8'hB1, 0, 2'b01, 1, 8'hA5, 0, 0));

        // Reset with both masters requesting.
        rst_b = 1'b1; m0_req_b = 1'b0; m1_req_b = 1'b0;
        m0_data_b = 8'h00; m1_data_b = 8'h00; s_ack_b = 1'b0;
        step(1'b1, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0);
        step(1'b1, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0);
        chk("rst grant", 8'(o_g), 8'h00);
        chk("rst busy", 8'(o_busy), 8'h00);
        chk("rst s_req", 8'(o_sr), 8'h00);
        chk("rst s_data", o_sd, 8'h00);
        chk("rst acks", 8'({o_a0, o_a1}), 8'h00);
        mon = 1;

        foreach (tbl[i]) begin
            step(1'b0, tbl[i].r0, tbl[i].d0, tbl[i].r1, tbl[i].d1, tbl[i].sa);
            chk("tbl grant", 8'(o_g), 8'(tbl[i].g));
            chk("tbl busy", 8'(o_busy), 8'(|tbl[i].g));
            chk("tbl s_req", 8'(o_sr), 8'(tbl[i].sr));
            chk("tbl s_data", o_sd, tbl[i].sd);
            chk("tbl m0_ack", 8'(o_a0), 8'(tbl[i].a0));
            chk("tbl m1_ack", 8'(o_a1), 8'(tbl[i].a1));
        end

        // Simultaneous requests: m0 burst first, then m1 by round robin.
        do_reset();
        seen.delete();
        step(1'b0, 1'b1, 8'hC0, 1'b1, 8'hB0, 1'b0);
        chk("tie idle", 8'(o_g), 8'h00);
        for (int k = 0; k < 4; k++) hs(1'b0, 8'(8'hC0 + k), 1'b1, 8'hB0);
        step(1'b0, 1'b1, 8'hC4, 1'b1, 8'hB0, 1'b0);
        chk("tie release", 8'(o_g), 8'h00);
        hs(1'b1, 8'hB0, 1'b1, 8'hC4);
        want = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hB0};
        chk("tie byte count", 8'(seen.size()), 8'(want.size()));
        foreach (want[i])
            if (i < seen.size()) chk("tie byte order", seen[i], want[i]);

        // Two bytes then idle: grant held for GAP cycles, then m1.
        do_reset();
        step(1'b0, 1'b1, 8'hD0, 1'b1, 8'hE0, 1'b0);
        hs(1'b0, 8'hD0, 1'b1, 8'hE0);
        hs(1'b0, 8'hD1, 1'b1, 8'hE0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 8'hD1, 1'b1, 8'hE0, 1'b0);
            chk("gap hold", 8'(o_g), 8'h01);
            chk("gap no fwd", 8'(o_sr), 8'h00);
        end
        step(1'b0, 1'b0, 8'hD1, 1'b1, 8'hE0, 1'b0);
        chk("gap release", 8'(o_g), 8'h00);
        step(1'b0, 1'b0, 8'hD1, 1'b1, 8'hE0, 1'b0);
        chk("gap next", 8'(o_g), 8'h02);
        chk("gap next data", o_sd, 8'hE0);

        // m1 arrives in m0's gap; m0 keeps the link for another byte.
        do_reset();
        step(1'b0, 1'b1, 8'h60, 1'b0, 8'h70, 1'b0);
        hs(1'b0, 8'h60, 1'b0, 8'h70);
        hs(1'b0, 8'h61, 1'b1, 8'h70);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 8'h61, 1'b1, 8'h70, 1'b0);
            chk("wait grant", 8'(o_g), 8'h01);
        end
        step(1'b0, 1'b0, 8'h61, 1'b1, 8'h70, 1'b0);
        chk("wait release", 8'(o_g), 8'h00);

        // Reset while the slave holds ack high.
        do_reset();
        step(1'b0, 1'b1, 8'hF0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'hF0, 1'b0, 8'h00, 1'b0);
        chk("mid grant", 8'(o_g), 8'h01);
        step(1'b0, 1'b1, 8'hF0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'hF0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'hF0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'hF0, 1'b0, 8'h00, 1'b1);
        chk("abort grant", 8'(o_g), 8'h00);
        chk("abort s_req", 8'(o_sr), 8'h00);
        chk("abort ack", 8'(o_a0), 8'h00);
        chk("abort data", o_sd, 8'h00);
        step(1'b0, 1'b1, 8'hF1, 1'b1, 8'h71, 1'b0);
        chk("abort idle", 8'(o_g), 8'h00);
        step(1'b0, 1'b1, 8'hF1, 1'b1, 8'h71, 1'b0);
        chk("abort regrant", 8'(o_g), 8'h01);
        chk("abort regrant data", o_sd, 8'hF1);

        // Owner drops req before ack: link stays parked on it.
        do_reset();
        step(1'b0, 1'b1, 8'h40, 1'b0, 8'h50, 1'b0);
        for (int k = 0; k < 6; k++)
            step(1'b0, 1'b0, 8'h40, 1'b1, 8'h50, 1'b0);
        chk("stuck grant", 8'(o_g), 8'h01);
        chk("stuck s_req", 8'(o_sr), 8'h00);

        // BURST=1 instance, both masters always asking.
        do_reset();
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        rst_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ow = k % 2;
            d0 = 8'(8'h10 + k);
            d1 = 8'(8'h20 + k);
            step_b(1'b1, d0, 1'b1, d1, 1'b0);
            chk("b1 idle", 8'(ob_g), 8'h00);
            for (int i = 0; i < 4; i++) begin
                r  = (i < 2);
                sa = (i == 1 || i == 2);
                step_b(ow == 0 ? r : 1'b1, d0, ow == 1 ? r : 1'b1, d1, sa);
                chk("b1 grant", 8'(ob_g), ow != 0 ? 8'h02 : 8'h01);
                chk("b1 data", ob_sd, ow != 0 ? d1 : d0);
                chk("b1 s_req", 8'(ob_sr), 8'(r));
                chk("b1 other ack", 8'(ow != 0 ? ob_a0 : ob_a1), 8'h00);
            end
        end

        // Randomized traffic on u0 against the model.
        do_reset();
        r0 = 1'b0; r1 = 1'b0; sa = 1'b0; d0 = 8'h00; d1 = 8'h00;
        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 299) == 0);
            if (!r0) begin
                d0 = 8'($urandom);
                if (!o_a0 && $urandom_range(0, 2) == 0) r0 = 1'b1;
            end else if (o_a0 ? ($urandom_range(0, 1) == 0)
                              : ($urandom_range(0, 99) == 0)) begin
                r0 = 1'b0;
            end
            if (!r1) begin
                d1 = 8'($urandom);
                if (!o_a1 && $urandom_range(0, 2) == 0) r1 = 1'b1;
            end else if (o_a1 ? ($urandom_range(0, 1) == 0)
                              : ($urandom_range(0, 99) == 0)) begin
                r1 = 1'b0;
            end
            if (o_sr != sa && $urandom_range(0, 1) == 0) sa = o_sr;
            else if ($urandom_range(0, 99) == 0) sa = ~sa;
            step(r, r0, d0, r1, d1, sa);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
